// File: rtl/lane_unpacker_pkg.sv
// Shared types and helpers for the lane unpacker: FSM states, a wide lane
// index type and the "no enabled lane above this one" test.
package lane_unpacker_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Helpers work on a fixed maximum width so any NLANES up to this fits.
    localparam int LANE_MAX = 64;

    typedef logic [$clog2(LANE_MAX)-1:0] lane_idx_t;

    function automatic logic lane_last(input logic [LANE_MAX-1:0] mask, input lane_idx_t idx);
        logic [LANE_MAX-1:0] above;
        above = (mask >> idx) >> 1;
        return above == '0;
    endfunction

endpackage

// File: rtl/lane_unpacker_pick.sv
// Lowest-set-bit priority encoder over a lane mask; also flags whether the
// selected lane is the only (and therefore last) enabled lane.
module lane_unpacker_pick
    import lane_unpacker_pkg::*;
#(
    parameter int NLANES = 8,
    parameter int IDX_W  = $clog2(NLANES)
) (
    input  logic [NLANES-1:0] mask,
    output logic [IDX_W-1:0]  idx,
    output logic              any,
    output logic              only_one
);

    always_comb begin
        idx = '0;
        for (int i = NLANES - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = IDX_W'(i);
            end
        end
        any      = |mask;
        only_one = any & lane_last(LANE_MAX'(mask), lane_idx_t'(idx));
    end

endmodule

// File: rtl/lane_unpacker.sv
// Unpacks one masked vector word into a valid/ready stream of lane beats,
// lowest enabled lane first, one beat per cycle with no bubbles.
//
//   state | meaning
//   IDLE  | no word held, ready for a new word
//   EMIT  | a beat is presented on out_*; held mask has lanes still to send
module lane_unpacker
    import lane_unpacker_pkg::*;
#(
    parameter  int NLANES = 8,
    parameter  int LANE_W = 1,
    localparam int IDX_W  = $clog2(NLANES)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NLANES*LANE_W-1:0] in_data,
    input  logic [NLANES-1:0]        in_mask,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANE_W-1:0]        out_data,
    output logic [IDX_W-1:0]         out_idx,
    output logic                     out_last,
    output logic                     busy
);

    state_t                     state_q, state_n;
    logic [NLANES*LANE_W-1:0]   data_q, data_n;
    logic [NLANES-1:0]          mask_q, mask_n;
    logic                       valid_n, last_n;
    logic [LANE_W-1:0]          odata_n;
    logic [IDX_W-1:0]           idx_n;

    logic                       accept, xfer;
    logic [NLANES-1:0]          mask_left, pick_mask;
    logic [NLANES*LANE_W-1:0]   lane_src;
    logic [IDX_W-1:0]           pick_idx;
    logic                       pick_any, pick_one;

    assign xfer      = out_valid & out_ready;
    assign in_ready  = (state_q == IDLE) | (xfer & out_last);
    assign accept    = in_valid & in_ready;
    assign busy      = (state_q != IDLE);
    assign mask_left = mask_q & ~(NLANES'(1) << out_idx);
    // An accept only happens when the held word is finished, so the encoder is free for it.
    assign pick_mask = accept ? in_mask : mask_left;
    assign lane_src  = accept ? in_data : data_q;

    lane_unpacker_pick #(
        .NLANES (NLANES),
        .IDX_W  (IDX_W)
    ) u_pick (
        .mask     (pick_mask),
        .idx      (pick_idx),
        .any      (pick_any),
        .only_one (pick_one)
    );

    always_comb begin
        state_n = state_q;
        data_n  = data_q;
        mask_n  = mask_q;
        valid_n = out_valid;
        odata_n = out_data;
        idx_n   = out_idx;
        last_n  = out_last;

        if (accept) begin
            data_n = in_data;
            mask_n = in_mask;
        end else if (xfer) begin
            mask_n = mask_left;
        end

        if (accept || xfer) begin
            if (pick_any) begin
                state_n = EMIT;
                valid_n = 1'b1;
                idx_n   = pick_idx;
                last_n  = pick_one;
                odata_n = lane_src[int'(pick_idx)*LANE_W +: LANE_W];
            end else begin
                state_n = IDLE;
                valid_n = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            mask_q    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else begin
            state_q   <= state_n;
            data_q    <= data_n;
            mask_q    <= mask_n;
            out_valid <= valid_n;
            out_data  <= odata_n;
            out_idx   <= idx_n;
            out_last  <= last_n;
        end
    end

endmodule

// File: tb/tb_lane_unpacker.sv
// Directed bench for lane_unpacker (NLANES=8, LANE_W=1): a table of words with
// hand-computed beat sequences, plus stall, back-to-back and mid-word reset cases.
module tb_lane_unpacker;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [7:0] in_mask;
    logic       out_valid;
    logic       out_ready;
    logic [0:0] out_data;
    logic [2:0] out_idx;
    logic       out_last;
    logic       busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]      data;
        logic [7:0]      mask;
        int              n;
        logic [7:0][2:0] idx;   // idx[k] = lane index of beat k
        logic [7:0]      bits;  // bits[k] = payload of beat k
    } vec_t;

    vec_t vecs [7];

    lane_unpacker #(.NLANES(8), .LANE_W(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mask   (in_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic check_beat(input string tag, input logic [2:0] idx, input logic dat, input logic last);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_idx"},   32'(out_idx),   32'(idx));
        check({tag, "_data"},  32'(out_data),  32'(dat));
        check({tag, "_last"},  32'(out_last),  32'(last));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid0"}, 32'(out_valid), 32'd0);
        check({tag, "_busy0"},  32'(busy),      32'd0);
        check({tag, "_ready1"}, 32'(in_ready),  32'd1);
    endtask

    // Offer one word, then expect its beats on consecutive cycles starting one cycle after accept.
    task automatic run_vec(input vec_t v, input int id);
        @(negedge clk);
        check($sformatf("v%0d_ready_before", id), 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = v.data;
        in_mask  = v.mask;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = ~v.data;
        for (int k = 0; k < v.n; k++) begin
            check_beat($sformatf("v%0d_b%0d", id, k), v.idx[k], v.bits[k], k == v.n - 1);
            @(negedge clk);
        end
        check_idle($sformatf("v%0d_end", id));
    endtask

    initial begin
        vecs[0] = '{8'hA5, 8'hFF, 8, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 8'hA5};
        vecs[1] = '{8'hA5, 8'hF7, 7, {3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd2, 3'd1, 3'd0}, 8'h55};
        vecs[2] = '{8'hA5, 8'h00, 0, 24'd0, 8'h00};
        vecs[3] = '{8'h3C, 8'h10, 1, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd4}, 8'h01};
        vecs[4] = '{8'h80, 8'h80, 1, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7}, 8'h01};
        vecs[5] = '{8'h5A, 8'h42, 2, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd6, 3'd1}, 8'h03};
        vecs[6] = '{8'h3C, 8'h3C, 4, {3'd0, 3'd0, 3'd0, 3'd0, 3'd5, 3'd4, 3'd3, 3'd2}, 8'h0F};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_mask   = 8'h00;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_idle("reset");
        check("reset_idx",  32'(out_idx),  32'd0);
        check("reset_data", 32'(out_data), 32'd0);
        check("reset_last", 32'(out_last), 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], i);
        end

        // Stall: beat idx1 held for two cycles while in_data wiggles.
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'hA5; in_mask = 8'hFF;
        @(negedge clk);
        in_valid = 1'b0;
        check_beat("st_b0", 3'd0, 1'b1, 1'b0);
        @(negedge clk);
        check_beat("st_b1", 3'd1, 1'b0, 1'b0);
        out_ready = 1'b0;
        in_data   = 8'h5A;
        @(negedge clk);
        check_beat("st_hold1", 3'd1, 1'b0, 1'b0);
        @(negedge clk);
        check_beat("st_hold2", 3'd1, 1'b0, 1'b0);
        out_ready = 1'b1;
        for (int k = 2; k < 8; k++) begin
            @(negedge clk);
            check_beat($sformatf("st_b%0d", k), 3'(k), vecs[0].bits[k], k == 7);
        end
        @(negedge clk);
        check_idle("st_end");

        // Back-to-back words: second accepted while the first word's last beat transfers.
        in_valid = 1'b1; in_data = 8'h0F; in_mask = 8'h81;
        @(negedge clk);
        in_valid = 1'b0;
        check_beat("bb_b0", 3'd0, 1'b1, 1'b0);
        check("bb_ready_mid", 32'(in_ready), 32'd0);
        @(negedge clk);
        check_beat("bb_b1", 3'd7, 1'b0, 1'b1);
        check("bb_ready_last", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_data = 8'hF0; in_mask = 8'h18;
        @(negedge clk);
        in_valid = 1'b0;
        check_beat("bb_b2", 3'd3, 1'b0, 1'b0);
        @(negedge clk);
        check_beat("bb_b3", 3'd4, 1'b1, 1'b1);
        @(negedge clk);
        check_idle("bb_end");

        // Reset after three of eight beats.
        in_valid = 1'b1; in_data = 8'hA5; in_mask = 8'hFF;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_beat("rs_b3", 3'd3, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_idle("rs_after");
        check("rs_idx", 32'(out_idx), 32'd0);
        rst = 1'b0;
        run_vec(vecs[6], 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
